// File: rtl/sodor5_seq_pkg.sv
// Shared definitions for the Sodor 5-stage instruction-stream sequencer.
// Holds the FSM state and generation-mode enums, the NOP word, the opcodes,
// the shift-immediate masks, the LFSR tap constant and the LFSR step helper.
package sodor5_seq_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_ITYPE = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_MIX   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [31:0] NOP           = 32'h00000013;
  localparam logic [6:0]  OP_IMM        = 7'b0010011;
  localparam logic [6:0]  OP_LOAD       = 7'b0000011;
  localparam logic [11:0] SRAI_IMM_MASK = 12'h41F;
  localparam logic [11:0] SLLI_IMM_MASK = 12'h01F;
  localparam logic [31:0] LFSR_TAPS     = 32'h80200003;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [31:0] lfsr_advance(input logic [31:0] r);
    lfsr_advance = {1'b0, r[31:1]} ^ (r[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/sodor5_seq_lfsr.sv
// 32-bit Galois LFSR used as the instruction-field source.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (loads SEED)
//   load           - reload SEED (restart of a run)
//   step           - advance one step
//   state          - current register value
//   next_state_c   - combinational value the register takes on a step
module sodor5_seq_lfsr
  import sodor5_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h00000070
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [31:0] state,
  output logic [31:0] next_state_c
);

  assign next_state_c = lfsr_advance(state);

  // Load takes priority over step so a restart always begins from SEED.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= SEED;
    end else if (step) begin
      state <= next_state_c;
    end
  end

endmodule

// File: rtl/sodor5_instr_sequencer.sv
// Replayable instruction-stream sequencer for the Sodor 5-stage core harness:
// NOP warm-up, N LFSR-generated I-type/load words, then a NOP drain.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin a run (honoured only in IDLE or DONE)
//   mode          - 0 ITYPE, 1 LOAD, 2 MIX, 3 as ITYPE; latched at start
//   num_instr     - number of generated words; latched at start
//   instr_ready   - core accepts instr this cycle
//   instr_valid   - instr is valid
//   instr         - instruction word
//   busy          - run in progress (WARMUP/ISSUE/DRAIN)
//   done          - run finished, held until the next start
//   issued_count  - generated words accepted in the current run
// WARMUP_CYCLES and DRAIN_CYCLES are expected to be at least 1.
module sodor5_instr_sequencer
  import sodor5_seq_pkg::*;
#(
  parameter logic [31:0] SEED          = 32'h00000070,
  parameter int unsigned WARMUP_CYCLES = 3,
  parameter int unsigned DRAIN_CYCLES  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_instr,
  input  logic             instr_ready,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued_count
);

  localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q;
  mode_e            mode_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] issued_inc;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_nxt;
  logic             accept;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             unused_lfsr_bits;

  assign accept     = instr_valid && instr_ready;
  assign lfsr_load  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
  assign lfsr_step  = (state_q == ST_ISSUE) && accept;
  assign issued_inc = CNT_W'(issued_count + CNT_W'(1));

  // Bits 6:1 of the LFSR never reach the instruction word.
  assign unused_lfsr_bits = ^{lfsr_q[6:1], lfsr_nxt[6:1]};

  sodor5_seq_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk          (clk),
    .reset        (reset),
    .load         (lfsr_load),
    .step         (lfsr_step),
    .state        (lfsr_q),
    .next_state_c (lfsr_nxt)
  );

  // Build an instruction from LFSR bits [31:7]; sel is LFSR bit 0 (MIX choice).
  function automatic logic [31:0] encode(input logic [31:7] f, input logic sel,
                                         input mode_e m);
    logic [11:0] imm;
    logic [2:0]  funct3;
    logic        use_load;
    imm      = f[31:20];
    funct3   = f[14:12];
    use_load = (m == MODE_LOAD) || ((m == MODE_MIX) && sel);
    if (use_load) begin
      funct3 = f[14] ? 3'b100 : 3'b000;
      encode = {imm, f[19:15], funct3, f[11:7], OP_LOAD};
    end else begin
      // Shift-immediates keep only the shamt and the arithmetic-shift bit.
      if (funct3 == 3'd5) begin
        imm = imm & SRAI_IMM_MASK;
      end else if (funct3 == 3'd1) begin
        imm = imm & SLLI_IMM_MASK;
      end
      encode = {imm, f[19:15], funct3, f[11:7], OP_IMM};
    end
  endfunction

  // Sequencer FSM; outputs change only on accepts, so a stall holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ITYPE;
      num_q        <= '0;
      phase_q      <= '0;
      issued_count <= '0;
      instr_valid  <= 1'b0;
      instr        <= NOP;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_WARMUP;
            mode_q       <= mode_e'(mode);
            num_q        <= num_instr;
            phase_q      <= '0;
            issued_count <= '0;
            instr_valid  <= 1'b1;
            instr        <= NOP;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end

        ST_WARMUP: begin
          if (accept) begin
            if (phase_q == WARMUP_LAST) begin
              phase_q <= '0;
              if (num_q == '0) begin
                state_q <= ST_DRAIN;
              end else begin
                state_q <= ST_ISSUE;
                instr   <= encode(lfsr_q[31:7], lfsr_q[0], mode_q);
              end
            end else begin
              phase_q <= CNT_W'(phase_q + CNT_W'(1));
            end
          end
        end

        ST_ISSUE: begin
          if (accept) begin
            issued_count <= issued_inc;
            if (issued_inc == num_q) begin
              state_q <= ST_DRAIN;
              instr   <= NOP;
            end else begin
              // Present the word for the LFSR value this edge steps to.
              instr <= encode(lfsr_nxt[31:7], lfsr_nxt[0], mode_q);
            end
          end
        end

        ST_DRAIN: begin
          if (accept) begin
            if (phase_q == DRAIN_LAST) begin
              state_q     <= ST_DONE;
              phase_q     <= '0;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              phase_q <= CNT_W'(phase_q + CNT_W'(1));
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          instr_valid <= 1'b0;
          instr       <= NOP;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sodor5_instr_sequencer.sv
// Scoreboard bench for sodor5_instr_sequencer: each run pushes its expected
// accepted-word stream from a behavioural model; a negedge monitor checks every
// presented word and issued_count against the queue head, popping on accepts.
module tb_sodor5_instr_sequencer;

  localparam logic [31:0] SEED   = 32'h5A5A5A5A;
  localparam int          WARM   = 3;
  localparam int          DRAIN  = 5;
  localparam logic [31:0] NOPW   = 32'h00000013;
  localparam int          BUDGET = 2000;

  typedef struct {
    logic [31:0] word;
    logic [15:0] cnt;
    bit          gen;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] num_instr;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        busy;
  logic        done;
  logic [15:0] issued_count;

  exp_t        sb[$];
  logic [31:0] got_gen[$];
  int          total;
  int          bad;

  sodor5_instr_sequencer #(
    .SEED          (SEED),
    .WARMUP_CYCLES (WARM),
    .DRAIN_CYCLES  (DRAIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .num_instr    (num_instr),
    .instr_ready  (instr_ready),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the LFSR value.
  function automatic logic [31:0] model_step(input logic [31:0] r);
    return (r >> 1) ^ (((r & 32'd1) != 0) ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] r, input int md);
    logic [31:0] imm, rs1, f3, rd, opc;
    bit          is_load;
    imm     = (r >> 20) & 32'hFFF;
    rs1     = (r >> 15) & 32'h1F;
    f3      = (r >> 12) & 32'h7;
    rd      = (r >> 7) & 32'h1F;
    is_load = (md == 1) || ((md == 2) && ((r & 32'd1) != 0));
    if (is_load) begin
      f3  = (((r >> 14) & 32'd1) != 0) ? 32'd4 : 32'd0;
      opc = 32'h03;
    end else begin
      opc = 32'h13;
      if (f3 == 32'd5) imm = imm & 32'h41F;
      else if (f3 == 32'd1) imm = imm & 32'h01F;
    end
    return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  task automatic push_run(input int md, input int n);
    logic [31:0] r;
    exp_t        e;
    for (int i = 0; i < WARM; i++) begin
      e.word = NOPW; e.cnt = 16'd0; e.gen = 1'b0; sb.push_back(e);
    end
    r = SEED;
    for (int i = 0; i < n; i++) begin
      e.word = model_word(r, md); e.cnt = 16'(i); e.gen = 1'b1; sb.push_back(e);
      r = model_step(r);
    end
    for (int i = 0; i < DRAIN; i++) begin
      e.word = NOPW; e.cnt = 16'(n); e.gen = 1'b0; sb.push_back(e);
    end
  endtask

  // Monitor: checks every presented word, pops the head on an accept.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && instr_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word got=%h exp=none", instr);
        end else begin
          chk("instr", instr, sb[0].word);
          chk("issued_count", 32'(issued_count), 32'(sb[0].cnt));
          if (instr_ready) begin
            if (sb[0].gen) got_gen.push_back(instr);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic run(input int md, input int n, input int pct, input int stall_at,
                     input int pulse_at, output int cycles);
    int cyc;
    bit fin;
    got_gen.delete();
    push_run(md, n);
    start       = 1'b1;
    mode        = 2'(md);
    num_instr   = 16'(n);
    instr_ready = 1'b1;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == pulse_at);
      if (start) begin
        mode      = 2'($urandom_range(0, 3));
        num_instr = 16'($urandom_range(1, 20));
      end
      if (cyc >= stall_at && cyc < stall_at + 3) instr_ready = 1'b0;
      else instr_ready = (int'($urandom_range(0, 99)) < pct);
      if (done) fin = 1'b1;
    end
    start  = 1'b0;
    cycles = cyc;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL run_timeout got=not_done exp=done mode=%0d n=%0d", md, n);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
    end else begin
      chk("end_done", 32'(done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_valid", 32'(instr_valid), 32'd0);
      chk("end_issued", 32'(issued_count), 32'(n));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("gen_count", 32'(got_gen.size()), 32'(n));
    end
  endtask

  initial begin
    int cyc;
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    start       = 1'b0;
    mode        = 2'd0;
    num_instr   = 16'd0;
    instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOPW);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_issued", 32'(issued_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ITYPE single word: srai with masked immediate.
    run(0, 1, 100, -100, -1, cyc);
    chk("itype_len", 32'(cyc), 32'd10);
    if (got_gen.size() > 0) chk("itype_word", got_gen[0], 32'h405A5A13);

    // LOAD single word: lbu.
    run(1, 1, 100, -100, -1, cyc);
    chk("load_len", 32'(cyc), 32'd10);
    if (got_gen.size() > 0) chk("load_word", got_gen[0], 32'h5A5A4A03);

    // Three-cycle stall right after the first ISSUE accept.
    run(0, 4, 100, 5, -1, cyc);
    chk("stall_len", 32'(cyc), 32'd16);

    // Zero generated instructions: warm-up straight into drain.
    run(2, 0, 100, -100, -1, cyc);
    chk("zero_len", 32'(cyc), 32'd9);

    // Reset mid-ISSUE after two accepts.
    start       = 1'b1;
    mode        = 2'd0;
    num_instr   = 16'd6;
    instr_ready = 1'b1;
    got_gen.delete();
    push_run(0, 6);
    repeat (6) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("mid_issued", 32'(issued_count), 32'd2);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_issued", 32'(issued_count), 32'd0);
    chk("mrst_instr", instr, NOPW);
    run(0, 2, 100, -100, -1, cyc);
    if (got_gen.size() > 0) chk("restart_word", got_gen[0], 32'h405A5A13);

    // start pulsed in DRAIN is ignored; a start in DONE replays the sequence.
    run(2, 3, 100, -100, 9, cyc);
    chk("drain_start_len", 32'(cyc), 32'd12);
    run(2, 3, 100, -100, -1, cyc);
    chk("replay_len", 32'(cyc), 32'd12);

    // Randomized runs with random back-pressure.
    for (int k = 0; k < 12; k++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 60, -100, -1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
